// File: rtl/layer_1_activation_buffer.sv
// Collects four groups of five layer-1 accumulators, ReLU-requantises each to SIZE bits,
// then streams the 20 activations to layer 2 over valid/ready, one per cycle.
module layer_1_activation_buffer #(
  parameter int SIZE   = 8,
  parameter int LANES  = 5,
  parameter int GROUPS = 4,
  parameter int SHIFT  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic signed [2*SIZE-1:0] accumulate_1,
  input  logic signed [2*SIZE-1:0] accumulate_2,
  input  logic signed [2*SIZE-1:0] accumulate_3,
  input  logic signed [2*SIZE-1:0] accumulate_4,
  input  logic signed [2*SIZE-1:0] accumulate_5,
  input  logic                   accumulate_signal,
  output logic                   fill_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIZE-1:0]        out_data,
  output logic [4:0]             out_index,
  output logic                   out_last,
  output logic                   overflow
);

  localparam int AW      = 2 * SIZE;
  localparam int NEURONS = LANES * GROUPS;
  localparam int GW      = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int MAXV    = (1 << (SIZE - 1)) - 1;
  localparam logic [GW-1:0] LAST_G   = GW'(GROUPS - 1);
  localparam logic [4:0]    LAST_IDX = 5'(NEURONS - 1);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;

  state_e          state_q;
  logic [GW-1:0]   g_q;
  logic [4:0]      idx_q;
  logic            overflow_q;
  logic            fill_ready_q;
  logic            out_valid_q;
  logic [SIZE-1:0] buf_q [NEURONS];

  logic signed [AW-1:0] lane_acc [LANES];
  logic [SIZE-1:0]      lane_act [LANES];
  logic                 transfer;
  logic                 last_xfer;
  logic                 capture;
  logic [4:0]           wr_base;

  function automatic logic [SIZE-1:0] requant(input logic signed [AW-1:0] a);
    logic [AW-1:0] q;
    q = '0;
    if (a <= 0) begin
      return '0;
    end
    q = a >>> SHIFT;
    if (q > AW'(MAXV)) begin
      return SIZE'(MAXV);
    end
    return q[SIZE-1:0];
  endfunction

  assign lane_acc[0] = accumulate_1;
  assign lane_acc[1] = accumulate_2;
  assign lane_acc[2] = accumulate_3;
  assign lane_acc[3] = accumulate_4;
  assign lane_acc[4] = accumulate_5;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_act[l] = requant(lane_acc[l]);
    end
  end

  assign transfer  = out_valid_q && out_ready;
  assign last_xfer = transfer && (idx_q == LAST_IDX);
  // The final-transfer cycle already belongs to the next image, so its strobe is kept.
  assign capture   = accumulate_signal && !flush && ((state_q == FILL) || last_xfer);
  assign wr_base   = 5'(g_q) * 5'(LANES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NEURONS; n++) begin
        buf_q[n] <= '0;
      end
    end else if (capture) begin
      for (int l = 0; l < LANES; l++) begin
        buf_q[wr_base + 5'(l)] <= lane_act[l];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FILL;
      g_q          <= '0;
      idx_q        <= '0;
      overflow_q   <= 1'b0;
      fill_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
    end else if (flush) begin
      state_q      <= FILL;
      g_q          <= '0;
      idx_q        <= '0;
      overflow_q   <= 1'b0;
      fill_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
    end else if (state_q == FILL) begin
      if (accumulate_signal) begin
        if (g_q == LAST_G) begin
          g_q          <= '0;
          idx_q        <= '0;
          state_q      <= DRAIN;
          fill_ready_q <= 1'b0;
          out_valid_q  <= 1'b1;
        end else begin
          g_q <= g_q + 1'b1;
        end
      end
    end else begin
      if (accumulate_signal && !last_xfer) begin
        overflow_q <= 1'b1;
      end
      if (transfer) begin
        if (last_xfer) begin
          idx_q        <= '0;
          state_q      <= FILL;
          fill_ready_q <= 1'b1;
          out_valid_q  <= 1'b0;
          if (accumulate_signal) begin
            g_q <= g_q + 1'b1;
          end
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  // Outputs derive only from registers, so they cannot move while the consumer stalls.
  assign fill_ready = fill_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_valid_q ? buf_q[idx_q] : '0;
  assign out_index  = idx_q;
  assign out_last   = out_valid_q && (idx_q == LAST_IDX);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_layer_1_activation_buffer.sv
// Bench for layer_1_activation_buffer: vector table plus scoreboard of expected transfers,
// with hand-written sequences for backpressure, overflow, boundary capture, reset and flush.
module tb_layer_1_activation_buffer;

  logic              clk;
  logic              reset;
  logic              flush;
  logic signed [15:0] acc [5];
  logic              accumulate_signal;
  logic              fill_ready;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [4:0]        out_index;
  logic              out_last;
  logic              overflow;

  typedef struct { logic [4:0] idx; logic [7:0] dat; logic last; } exp_t;
  typedef struct { logic signed [15:0] acc; logic [7:0] want; } vec_t;

  exp_t              sb [$];
  vec_t              tbl [20];
  logic signed [15:0] img_acc [20];
  logic [7:0]        img_exp [20];
  int                checks = 0;
  int                errors = 0;
  int                xfer_cnt = 0;
  int                stall_cnt = 0;
  int                rdy_mode = 0;
  logic              rdy_manual = 1'b1;

  layer_1_activation_buffer dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .accumulate_1      (acc[0]),
    .accumulate_2      (acc[1]),
    .accumulate_3      (acc[2]),
    .accumulate_4      (acc[3]),
    .accumulate_5      (acc[4]),
    .accumulate_signal (accumulate_signal),
    .fill_ready        (fill_ready),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_index         (out_index),
    .out_last          (out_last),
    .overflow          (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, want);
    end
  endtask

  // Pops one expected record per handshake seen at the falling edge.
  task automatic monitor();
    exp_t e;
    exp_t held;
    logic stalled;
    stalled = 1'b0;
    held = '{idx: '0, dat: '0, last: 1'b0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        chk($sformatf("hold_data_idx%0d", held.idx), out_data, held.dat);
        chk("hold_index", out_index, held.idx);
        chk("hold_last", out_last, held.last);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got index %0d data %0d, required no transfer", out_index, out_data);
        end else begin
          e = sb.pop_front();
          chk($sformatf("data_idx%0d", e.idx), out_data, e.dat);
          chk("index", out_index, e.idx);
          chk($sformatf("last_idx%0d", e.idx), out_last, e.last);
        end
        xfer_cnt++;
      end
      stalled = out_valid && !out_ready;
      if (stalled) stall_cnt++;
      held = '{idx: out_index, dat: out_data, last: out_last};
    end
  endtask

  task automatic ready_driver();
    logic [5:0] pat;
    int pi;
    pat = 6'b101001;
    pi = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        out_ready = 1'b1;
      end else if (rdy_mode == 1) begin
        out_ready = pat[pi];
        pi = (pi + 1) % 6;
      end else begin
        out_ready = rdy_manual;
      end
    end
  endtask

  task automatic load_ramp(input int base, input int off);
    for (int n = 0; n < 20; n++) begin
      img_acc[n] = 16'(64 * (n + base) + off);
      img_exp[n] = 8'(n + base);
    end
  endtask

  task automatic drive_group(input int g);
    for (int l = 0; l < 5; l++) begin
      acc[l] = img_acc[g * 5 + l];
      sb.push_back('{idx: 5'(g * 5 + l), dat: img_exp[g * 5 + l], last: ((g * 5 + l) == 19)});
    end
  endtask

  // Called just after a rising edge; returns just after the edge of the last strobe.
  task automatic send_groups(input int first_g, input int gap);
    for (int g = first_g; g < 4; g++) begin
      chk($sformatf("fill_ready_before_g%0d", g), fill_ready, 1);
      chk($sformatf("no_valid_before_g%0d", g), out_valid, 0);
      drive_group(g);
      accumulate_signal = 1'b1;
      @(posedge clk);
      #1;
      accumulate_signal = 1'b0;
      if (g != 3) repeat (gap) begin @(posedge clk); #1; end
    end
    chk("drain_starts_valid", out_valid, 1);
    chk("drain_starts_index", out_index, 0);
    chk("drain_starts_fill_ready", fill_ready, 0);
  endtask

  task automatic wait_drain(input string name, input int base, output int cyc);
    cyc = 0;
    while ((sb.size() != 0 || out_valid) && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, "_completed"}, int'(cyc < 400), 1);
    chk({name, "_xfers"}, xfer_cnt - base, 20);
    chk({name, "_fill_ready_after"}, fill_ready, 1);
  endtask

  task automatic wait_index(input int target);
    int n;
    n = 0;
    while (!(out_valid && out_index == 5'(target)) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_index: got index %0d valid %0d, required index %0d", out_index, out_valid, target);
    end
  endtask

  task automatic strobe_junk();
    for (int l = 0; l < 5; l++) acc[l] = 16'sh7fff;
    accumulate_signal = 1'b1;
    @(posedge clk);
    #1;
    accumulate_signal = 1'b0;
  endtask

  initial begin
    int base;
    int cyc;
    reset = 1'b1;
    flush = 1'b0;
    accumulate_signal = 1'b0;
    for (int l = 0; l < 5; l++) acc[l] = '0;
    fork
      monitor();
      ready_driver();
    join_none

    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fill_ready", fill_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b1;
    repeat (50) begin
      @(posedge clk);
      #1;
      chk("idle_out_valid", out_valid, 0);
      chk("idle_fill_ready", fill_ready, 1);
      chk("idle_overflow", overflow, 0);
    end

    // Requantisation corners; first group is the canonical 64,-5,10000,0,640 set.
    tbl[0]  = '{16'sd64,    8'd1};
    tbl[1]  = '{-16'sd5,    8'd0};
    tbl[2]  = '{16'sd10000, 8'd127};
    tbl[3]  = '{16'sd0,     8'd0};
    tbl[4]  = '{16'sd640,   8'd10};
    tbl[5]  = '{16'sd63,    8'd0};
    tbl[6]  = '{16'sd127,   8'd1};
    tbl[7]  = '{16'sd8191,  8'd127};
    tbl[8]  = '{16'sd8192,  8'd127};
    tbl[9]  = '{16'sd32767, 8'd127};
    tbl[10] = '{16'sh8000,  8'd0};
    tbl[11] = '{16'sd8127,  8'd126};
    tbl[12] = '{16'sd1,     8'd0};
    tbl[13] = '{-16'sd1,    8'd0};
    tbl[14] = '{16'sd128,   8'd2};
    tbl[15] = '{16'sd191,   8'd2};
    tbl[16] = '{16'sd192,   8'd3};
    tbl[17] = '{16'sd4096,  8'd64};
    tbl[18] = '{16'sd6400,  8'd100};
    tbl[19] = '{16'sd8000,  8'd125};
    for (int n = 0; n < 20; n++) begin
      img_acc[n] = tbl[n].acc;
      img_exp[n] = tbl[n].want;
    end
    base = xfer_cnt;
    send_groups(0, 1);
    wait_drain("requant", base, cyc);

    // Full-image ordering with strobes 3 cycles apart; ready held high.
    load_ramp(0, 0);
    base = xfer_cnt;
    send_groups(0, 3);
    wait_drain("order", base, cyc);
    chk("order_drain_cycles", cyc, 20);

    // Backpressure with ready pattern 1,0,0,1,0,1 and back-to-back strobes.
    rdy_mode = 1;
    load_ramp(40, 63);
    base = xfer_cnt;
    stall_cnt = 0;
    send_groups(0, 0);
    wait_drain("backpressure", base, cyc);
    chk("bp_stalls_seen", int'(stall_cnt > 0), 1);
    rdy_mode = 2;
    rdy_manual = 1'b1;
    @(posedge clk);
    #1;

    // Strobes mid-drain are dropped; one on the final transfer opens the next image.
    load_ramp(50, 20);
    send_groups(0, 1);
    wait_index(2);
    strobe_junk();
    chk("ovf_after_idx2", overflow, 1);
    wait_index(7);
    strobe_junk();
    chk("ovf_after_idx7", overflow, 1);
    chk("still_draining_after_drop", out_valid, 1);
    wait_index(19);
    load_ramp(60, 5);
    drive_group(0);
    accumulate_signal = 1'b1;
    @(posedge clk);
    #1;
    accumulate_signal = 1'b0;
    chk("boundary_fill_ready", fill_ready, 1);
    chk("boundary_out_valid", out_valid, 0);
    chk("boundary_ovf_sticky", overflow, 1);
    base = xfer_cnt;
    send_groups(1, 1);
    wait_drain("boundary_image", base, cyc);
    chk("ovf_still_sticky", overflow, 1);
    rdy_mode = 0;

    // Flush at index 10: synchronous, also clears overflow.
    load_ramp(10, 1);
    send_groups(0, 1);
    wait_index(10);
    flush = 1'b1;
    chk("flush_not_before_edge", out_valid, 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_fill_ready", fill_ready, 1);
    chk("flush_out_index", out_index, 0);
    chk("flush_out_last", out_last, 0);
    chk("flush_out_data", out_data, 0);
    chk("flush_overflow", overflow, 0);
    sb.delete();
    load_ramp(30, 9);
    base = xfer_cnt;
    send_groups(0, 2);
    wait_drain("after_flush", base, cyc);

    // Asynchronous reset at index 10: outputs drop without waiting for a clock edge.
    load_ramp(20, 3);
    send_groups(0, 1);
    wait_index(10);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_fill_ready", fill_ready, 1);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_index", out_index, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_overflow", overflow, 0);
    sb.delete();
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    load_ramp(70, 11);
    base = xfer_cnt;
    send_groups(0, 1);
    wait_drain("after_reset", base, cyc);
    chk("after_reset_drain_cycles", cyc, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
